regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port register file for the ARM CPU datapath. It is the successor to the single-write, dual-read 16x32 register file. It adds configurable width, depth and port counts; multiple write ports with fixed priority; optional write-to-read bypass; per-port read enables that hold output; and synchronous clear on reset. It sits between decode (register read) and writeback, and serves dual-issue and load-writeback paths.

Parameters:
DATA_W, 32, width of each register in bits
ADDR_W, 4, register address width; depth is 2**ADDR_W
NUM_RD, 3, number of read ports (1..4)
NUM_WR, 2, number of write ports (1..2)
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = read returns pre-write contents

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clears all registers and read outputs
wr_en  in  NUM_WR  per-write-port enable
wr_addr  in  NUM_WR*ADDR_W  write addresses, port k at bits [k*ADDR_W +: ADDR_W]
wr_data  in  NUM_WR*DATA_W  write data, port k at bits [k*DATA_W +: DATA_W]
rd_en  in  NUM_RD  per-read-port enable
rd_addr  in  NUM_RD*ADDR_W  read addresses, packed as for wr_addr
rd_data  out  NUM_RD*DATA_W  registered read data, packed as for wr_data
wr_conflict  out  1  registered flag: two enabled write ports targeted the same address in the previous cycle

Behaviour:
- Reset (synchronous, rising clk, reset=1):
  - every register is set to 0
  - every rd_data lane is set to 0; wr_conflict is set to 0
  - all writes and reads in that cycle are ignored
  - reset asserted mid-stream discards any in-flight write
- Write:
  - on a rising edge with reset=0 and wr_en[k]=1, reg[wr_addr[k]] <= wr_data[k]
  - the value is visible to registered reads from the next edge onward
- Write priority: when two enabled write ports share an address, the higher port index wins. wr_conflict is 1 the cycle after the collision and 0 otherwise.
- Read latency is 1 cycle.
  - rd_en[j]=1 at edge N: rd_data[j] holds the selected value from after edge N.
  - rd_en[j]=0: rd_data[j] holds its previous value (no change).
- Bypass with BYPASS=1, when rd_en[j]=1 and some enabled write port targets rd_addr[j] in the same cycle:
  - rd_data[j] takes the winning write port's wr_data (write-first)
  - priority among multiple matching writes follows the write-priority rule
- Bypass with BYPASS=0: the same case returns the register's old contents (read-first, matching the legacy block).
- Multiple read ports may address the same register; each gets identical data.
- Address range: all 2**ADDR_W addresses are valid; there is no wrap or out-of-range case. Register 0 is an ordinary register (not hard-wired zero).
- No combinational path from any input to any output.

Decomposition:
- Shared package regfile_pkg:
  - default DATA_W/ADDR_W constants (32/4)
  - ARM register index constants: REG_SP=13, REG_LR=14, REG_PC=15
- One natural sub-module, regfile_wr_arb: combinational per-address write-select. Inputs are wr_en/wr_addr/wr_data and a query address. Outputs are a hit flag and the winning data. It is instantiated once per register (commit) and once per read port (bypass).
- Storage and read registers stay in regfile_mp.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, then assert reset 1 cycle, then read r5 -> rd_data=0x00000000 one cycle after the read; wr_conflict=0.
- Basic write/read: wr0 writes 0x12345678 to r3; the next cycle rd1 reads r3 -> rd_data[1]=0x12345678 after 1 edge; rd0 reading r4 (unwritten since reset) -> 0.
- Write collision: same cycle wr0 writes (r7, 0x1111) and wr1 writes (r7, 0x2222) -> r7 reads 0x2222 afterwards; wr_conflict=1 for exactly one cycle.
- Bypass: BYPASS=1, r9=0xA0. Same cycle wr0 writes (r9, 0xB0) and rd2 reads r9 -> rd_data[2]=0xB0. Rerun with BYPASS=0 -> 0xA0, and 0xB0 on the following read.
- Read hold: rd0 reads r2=0x55, then rd_en[0]=0 for 3 cycles while r2 is written 0x66 -> rd_data[0] stays 0x55. Re-enable -> 0x66.
- Reset mid-write: reset=1 in the same cycle as wr0 writes (r1, 0xFF) -> r1 reads 0 after reset deasserts.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port ARM register file.
package regfile_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_ADDR_W = 4;

   // Architectural register indices with special roles in the ARM datapath
   localparam int unsigned REG_SP = 13;
   localparam int unsigned REG_LR = 14;
   localparam int unsigned REG_PC = 15;

endpackage

// File: rtl/regfile_mp_if.sv
// Register file bus: packed write ports, packed read ports, collision flag.
interface regfile_mp_if
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned NUM_RD = 3,
   parameter int unsigned NUM_WR = 2
);

   logic [NUM_WR-1:0]        wr_en;
   logic [NUM_WR*ADDR_W-1:0] wr_addr;
   logic [NUM_WR*DATA_W-1:0] wr_data;
   logic [NUM_RD-1:0]        rd_en;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic                     wr_conflict;

   modport master (
      output wr_en, wr_addr, wr_data, rd_en, rd_addr,
      input  rd_data, wr_conflict
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
      output rd_data, wr_conflict
   );

endinterface

// File: rtl/regfile_wr_arb.sv
// Per-address write select: higher-indexed enabled port matching the query wins.
module regfile_wr_arb
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned NUM_WR = 2
) (
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0]        query,
   output logic                     hit_c,
   output logic [DATA_W-1:0]        data_c
);

   // Scan ports low to high so the last match (highest index) takes effect
   always_comb begin
      hit_c  = 1'b0;
      data_c = '0;
      for (int k = 0; k < int'(NUM_WR); k++) begin
         if (wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] == query)) begin
            hit_c  = 1'b1;
            data_c = wr_data[k*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with prioritised writes,
// optional write-to-read bypass and registered, enable-held read ports.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned NUM_RD = 3,
   parameter int unsigned NUM_WR = 2,
   parameter int unsigned BYPASS = 1
) (
   input  logic        clk,
   input  logic        reset,
   regfile_mp_if.slave bus
);

   localparam int unsigned DEPTH  = 2 ** ADDR_W;
   localparam bit          BYP_EN = (BYPASS != 0);

   logic [DATA_W-1:0] regs     [DEPTH];
   logic [DEPTH-1:0]  cmt_hit;
   logic [DATA_W-1:0] cmt_data [DEPTH];
   logic [NUM_RD-1:0] byp_hit;
   logic [DATA_W-1:0] byp_data [NUM_RD];
   logic [DATA_W-1:0] rd_next  [NUM_RD];
   logic [DATA_W-1:0] rd_q     [NUM_RD];
   logic              conflict_c;
   logic              conflict_q;

   // One write arbiter per register decides its commit value
   for (genvar r = 0; r < int'(DEPTH); r++) begin : g_cmt
      regfile_wr_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR)) u_arb (
         .wr_en   (bus.wr_en),
         .wr_addr (bus.wr_addr),
         .wr_data (bus.wr_data),
         .query   (ADDR_W'(r)),
         .hit_c   (cmt_hit[r]),
         .data_c  (cmt_data[r])
      );
   end

   // One write arbiter per read port supplies same-cycle forwarding data
   for (genvar j = 0; j < int'(NUM_RD); j++) begin : g_byp
      regfile_wr_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR)) u_arb (
         .wr_en   (bus.wr_en),
         .wr_addr (bus.wr_addr),
         .wr_data (bus.wr_data),
         .query   (bus.rd_addr[j*ADDR_W +: ADDR_W]),
         .hit_c   (byp_hit[j]),
         .data_c  (byp_data[j])
      );
      assign bus.rd_data[j*DATA_W +: DATA_W] = rd_q[j];
   end

   // Read mux: stored value, or winning write data when forwarding is on
   always_comb begin
      for (int j = 0; j < int'(NUM_RD); j++) begin
         rd_next[j] = regs[bus.rd_addr[j*ADDR_W +: ADDR_W]];
         if (BYP_EN && byp_hit[j]) begin
            rd_next[j] = byp_data[j];
         end
      end
   end

   // Flag any pair of enabled write ports aimed at the same register
   always_comb begin
      conflict_c = 1'b0;
      for (int i = 0; i < int'(NUM_WR); i++) begin
         for (int k = i + 1; k < int'(NUM_WR); k++) begin
            if (bus.wr_en[i] && bus.wr_en[k] &&
                (bus.wr_addr[i*ADDR_W +: ADDR_W] == bus.wr_addr[k*ADDR_W +: ADDR_W])) begin
               conflict_c = 1'b1;
            end
         end
      end
   end

   // Register storage; reset wins over any write in the same cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < int'(DEPTH); r++) begin
            regs[r] <= '0;
         end
      end else begin
         for (int r = 0; r < int'(DEPTH); r++) begin
            if (cmt_hit[r]) begin
               regs[r] <= cmt_data[r];
            end
         end
      end
   end

   // Read output registers hold while their enable is low
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int j = 0; j < int'(NUM_RD); j++) begin
            rd_q[j] <= '0;
         end
         conflict_q <= 1'b0;
      end else begin
         for (int j = 0; j < int'(NUM_RD); j++) begin
            if (bus.rd_en[j]) begin
               rd_q[j] <= rd_next[j];
            end
         end
         conflict_q <= conflict_c;
      end
   end

   assign bus.wr_conflict = conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a forwarding and a non-forwarding
// instance driven by identical stimulus.
module tb_regfile_mp;
   import regfile_pkg::*;

   logic        clk;
   logic        reset;
   logic [1:0]  wr_en;
   logic [7:0]  wr_addr;
   logic [63:0] wr_data;
   logic [2:0]  rd_en;
   logic [11:0] rd_addr;
   logic [95:0] rd_b, rd_n;
   logic        cf_b, cf_n;

   int tests = 0;
   int fails = 0;

   regfile_mp_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3), .NUM_WR(2)) bus_b ();
   regfile_mp_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3), .NUM_WR(2)) bus_n ();

   assign bus_b.wr_en   = wr_en;
   assign bus_b.wr_addr = wr_addr;
   assign bus_b.wr_data = wr_data;
   assign bus_b.rd_en   = rd_en;
   assign bus_b.rd_addr = rd_addr;
   assign bus_n.wr_en   = wr_en;
   assign bus_n.wr_addr = wr_addr;
   assign bus_n.wr_data = wr_data;
   assign bus_n.rd_en   = rd_en;
   assign bus_n.rd_addr = rd_addr;
   assign rd_b = bus_b.rd_data;
   assign rd_n = bus_n.rd_data;
   assign cf_b = bus_b.wr_conflict;
   assign cf_n = bus_n.wr_conflict;

   regfile_mp #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3), .NUM_WR(2), .BYPASS(1)) u_dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   regfile_mp #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3), .NUM_WR(2), .BYPASS(0)) u_dut_n (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] lane(input logic [95:0] v, input int j);
      return v[j*32 +: 32];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en   = '0;
      wr_addr = '0;
      wr_data = '0;
      rd_en   = '0;
      rd_addr = '0;
   endtask

   task automatic set_wr(input int k, input logic [3:0] a, input logic [31:0] d);
      wr_en[k]            = 1'b1;
      wr_addr[k*4 +: 4]   = a;
      wr_data[k*32 +: 32] = d;
   endtask

   task automatic set_rd(input int j, input logic [3:0] a);
      rd_en[j]          = 1'b1;
      rd_addr[j*4 +: 4] = a;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      step();
      tests++; if (rd_b !== 96'h0) begin fails++; $display("FAIL reset_rd_b got %h exp 0", rd_b); end
      tests++; if (rd_n !== 96'h0) begin fails++; $display("FAIL reset_rd_n got %h exp 0", rd_n); end
      tests++; if (cf_b !== 1'b0) begin fails++; $display("FAIL reset_cf got %b exp 0", cf_b); end
      reset = 1'b0;
      set_wr(0, 4'd5, 32'hDEADBEEF);
      step();
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
      set_rd(0, 4'd5);
      step();
      idle();
      tests++; if (lane(rd_b, 0) !== 32'h0) begin fails++; $display("FAIL reset_r5 got %h exp 00000000", lane(rd_b, 0)); end
      tests++; if (cf_b !== 1'b0) begin fails++; $display("FAIL reset_r5_cf got %b exp 0", cf_b); end
   endtask

   task automatic test_basic();
      set_wr(0, 4'd3, 32'h12345678);
      step();
      idle();
      set_rd(1, 4'd3);
      set_rd(0, 4'd4);
      step();
      idle();
      tests++; if (lane(rd_b, 1) !== 32'h12345678) begin fails++; $display("FAIL basic_r3 got %h exp 12345678", lane(rd_b, 1)); end
      tests++; if (lane(rd_n, 1) !== 32'h12345678) begin fails++; $display("FAIL basic_r3_n got %h exp 12345678", lane(rd_n, 1)); end
      tests++; if (lane(rd_b, 0) !== 32'h0) begin fails++; $display("FAIL basic_r4 got %h exp 00000000", lane(rd_b, 0)); end
   endtask

   task automatic test_collision();
      set_wr(0, 4'd7, 32'h1111);
      set_wr(1, 4'd7, 32'h2222);
      step();
      idle();
      tests++; if (cf_b !== 1'b1) begin fails++; $display("FAIL coll_flag got %b exp 1", cf_b); end
      tests++; if (cf_n !== 1'b1) begin fails++; $display("FAIL coll_flag_n got %b exp 1", cf_n); end
      set_rd(0, 4'd7);
      step();
      idle();
      tests++; if (cf_b !== 1'b0) begin fails++; $display("FAIL coll_flag_drop got %b exp 0", cf_b); end
      tests++; if (lane(rd_b, 0) !== 32'h2222) begin fails++; $display("FAIL coll_r7 got %h exp 00002222", lane(rd_b, 0)); end
      tests++; if (lane(rd_n, 0) !== 32'h2222) begin fails++; $display("FAIL coll_r7_n got %h exp 00002222", lane(rd_n, 0)); end
      // Distinct addresses on both ports: no collision, both committed
      set_wr(0, 4'(REG_SP), 32'h0000_0013);
      set_wr(1, 4'(REG_LR), 32'h0000_0014);
      step();
      idle();
      tests++; if (cf_b !== 1'b0) begin fails++; $display("FAIL nocoll_flag got %b exp 0", cf_b); end
      set_rd(0, 4'(REG_SP));
      set_rd(1, 4'(REG_LR));
      step();
      idle();
      tests++; if (lane(rd_b, 0) !== 32'h13) begin fails++; $display("FAIL nocoll_sp got %h exp 00000013", lane(rd_b, 0)); end
      tests++; if (lane(rd_b, 1) !== 32'h14) begin fails++; $display("FAIL nocoll_lr got %h exp 00000014", lane(rd_b, 1)); end
   endtask

   task automatic test_bypass();
      set_wr(0, 4'd9, 32'hA0);
      step();
      idle();
      set_wr(0, 4'd9, 32'hB0);
      set_rd(2, 4'd9);
      step();
      idle();
      tests++; if (lane(rd_b, 2) !== 32'hB0) begin fails++; $display("FAIL byp_on got %h exp 000000b0", lane(rd_b, 2)); end
      tests++; if (lane(rd_n, 2) !== 32'hA0) begin fails++; $display("FAIL byp_off got %h exp 000000a0", lane(rd_n, 2)); end
      set_rd(2, 4'd9);
      step();
      idle();
      tests++; if (lane(rd_b, 2) !== 32'hB0) begin fails++; $display("FAIL byp_on_next got %h exp 000000b0", lane(rd_b, 2)); end
      tests++; if (lane(rd_n, 2) !== 32'hB0) begin fails++; $display("FAIL byp_off_next got %h exp 000000b0", lane(rd_n, 2)); end
      // Two matching writes: forwarding follows the higher port
      set_wr(0, 4'd10, 32'h1);
      set_wr(1, 4'd10, 32'h2);
      set_rd(0, 4'd10);
      step();
      idle();
      tests++; if (lane(rd_b, 0) !== 32'h2) begin fails++; $display("FAIL byp_prio got %h exp 00000002", lane(rd_b, 0)); end
      tests++; if (lane(rd_n, 0) !== 32'h0) begin fails++; $display("FAIL byp_prio_off got %h exp 00000000", lane(rd_n, 0)); end
   endtask

   task automatic test_multi_read();
      set_wr(1, 4'(REG_PC), 32'hCAFEF00D);
      set_wr(0, 4'd0, 32'h1);
      step();
      idle();
      set_rd(0, 4'(REG_PC));
      set_rd(1, 4'(REG_PC));
      set_rd(2, 4'(REG_PC));
      step();
      idle();
      for (int j = 0; j < 3; j++) begin
         tests++; if (lane(rd_b, j) !== 32'hCAFEF00D) begin fails++; $display("FAIL multi_pc lane%0d got %h exp cafef00d", j, lane(rd_b, j)); end
      end
      set_rd(1, 4'd0);
      step();
      idle();
      tests++; if (lane(rd_n, 1) !== 32'h1) begin fails++; $display("FAIL reg0_plain got %h exp 00000001", lane(rd_n, 1)); end
   endtask

   task automatic test_hold();
      set_wr(0, 4'd2, 32'h55);
      step();
      idle();
      set_rd(0, 4'd2);
      step();
      idle();
      tests++; if (lane(rd_b, 0) !== 32'h55) begin fails++; $display("FAIL hold_first got %h exp 00000055", lane(rd_b, 0)); end
      for (int c = 0; c < 3; c++) begin
         idle();
         set_wr(0, 4'd2, 32'h66);
         step();
         tests++; if (lane(rd_b, 0) !== 32'h55) begin fails++; $display("FAIL hold_c%0d got %h exp 00000055", c, lane(rd_b, 0)); end
         tests++; if (lane(rd_n, 0) !== 32'h55) begin fails++; $display("FAIL hold_n_c%0d got %h exp 00000055", c, lane(rd_n, 0)); end
      end
      idle();
      set_rd(0, 4'd2);
      step();
      idle();
      tests++; if (lane(rd_b, 0) !== 32'h66) begin fails++; $display("FAIL hold_reen got %h exp 00000066", lane(rd_b, 0)); end
   endtask

   task automatic test_reset_mid();
      reset = 1'b1;
      set_wr(0, 4'd1, 32'hFF);
      set_rd(2, 4'(REG_PC));
      step();
      reset = 1'b0;
      idle();
      tests++; if (rd_b !== 96'h0) begin fails++; $display("FAIL rstmid_lanes got %h exp 0", rd_b); end
      tests++; if (cf_n !== 1'b0) begin fails++; $display("FAIL rstmid_cf got %b exp 0", cf_n); end
      set_rd(0, 4'd1);
      set_rd(1, 4'd2);
      step();
      idle();
      tests++; if (lane(rd_b, 0) !== 32'h0) begin fails++; $display("FAIL rstmid_r1 got %h exp 00000000", lane(rd_b, 0)); end
      tests++; if (lane(rd_n, 1) !== 32'h0) begin fails++; $display("FAIL rstmid_r2 got %h exp 00000000", lane(rd_n, 1)); end
   endtask

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_basic();
      test_collision();
      test_bypass();
      test_multi_read();
      test_hold();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
